// File: rtl/nb_cell_iter_ctrl.sv
// Half-shell neighbour iterator: walks the 14 neighbour cells of one home cell
// with periodic wrap per axis and streams their IDs on a valid/ready interface.

module nb_cell_axis_wrap #(
  parameter int W = 3
) (
  input  logic [W-1:0] home,
  input  logic [1:0]   d,
  input  logic [W-1:0] maxv,
  output logic [W-1:0] nb
);
  always_comb begin
    nb = home;
    case (d)
      2'b01:   nb = (home == maxv) ? '0 : home + W'(1);
      2'b11:   nb = (home == '0) ? maxv : home - W'(1);
      default: nb = home;
    endcase
  end
endmodule

module nb_cell_iter_ctrl #(
  parameter int CELL_ID_WIDTH = 3,
  parameter int X_DIM = 3,
  parameter int Y_DIM = 3,
  parameter int Z_DIM = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [CELL_ID_WIDTH-1:0] i_home_cid_x,
  input  logic [CELL_ID_WIDTH-1:0] i_home_cid_y,
  input  logic [CELL_ID_WIDTH-1:0] i_home_cid_z,
  output logic                     o_busy,
  output logic                     o_nb_valid,
  input  logic                     i_nb_ready,
  output logic [CELL_ID_WIDTH-1:0] o_nb_cid_x,
  output logic [CELL_ID_WIDTH-1:0] o_nb_cid_y,
  output logic [CELL_ID_WIDTH-1:0] o_nb_cid_z,
  output logic [3:0]               o_nb_idx,
  output logic                     o_nb_last,
  output logic                     o_done,
  output logic                     o_err
);
  localparam int W = CELL_ID_WIDTH;
  localparam logic [1:0] D0 = 2'b00, DP = 2'b01, DN = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state;
  logic [3:0]          k, k_next;
  logic [2:0][W-1:0]   home, dim_max, nb_next;
  logic [2:0][1:0]     d_next;
  logic                in_range;

  assign dim_max  = {W'(Z_DIM - 1), W'(Y_DIM - 1), W'(X_DIM - 1)};
  assign in_range = (int'(i_home_cid_x) < X_DIM) && (int'(i_home_cid_y) < Y_DIM) &&
                    (int'(i_home_cid_z) < Z_DIM);
  assign k_next   = k + 4'd1;
  assign o_nb_idx = k;

  // Offset of the beat after the current one, packed {dz, dy, dx}.
  always_comb begin
    d_next = '0;
    case (k_next)
      4'd1:    d_next = {D0, D0, DP};
      4'd2:    d_next = {D0, DP, DN};
      4'd3:    d_next = {D0, DP, D0};
      4'd4:    d_next = {D0, DP, DP};
      4'd5:    d_next = {DP, DN, DN};
      4'd6:    d_next = {DP, DN, D0};
      4'd7:    d_next = {DP, DN, DP};
      4'd8:    d_next = {DP, D0, DN};
      4'd9:    d_next = {DP, D0, D0};
      4'd10:   d_next = {DP, D0, DP};
      4'd11:   d_next = {DP, DP, DN};
      4'd12:   d_next = {DP, DP, D0};
      4'd13:   d_next = {DP, DP, DP};
      default: d_next = '0;
    endcase
  end

  for (genvar a = 0; a < 3; a++) begin : g_axis
    nb_cell_axis_wrap #(.W(W)) u_wrap (
      .home (home[a]),
      .d    (d_next[a]),
      .maxv (dim_max[a]),
      .nb   (nb_next[a])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      home       <= '0;
      o_busy     <= 1'b0;
      o_nb_valid <= 1'b0;
      o_nb_cid_x <= '0;
      o_nb_cid_y <= '0;
      o_nb_cid_z <= '0;
      o_nb_last  <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && in_range) begin
            home       <= {i_home_cid_z, i_home_cid_y, i_home_cid_x};
            k          <= '0;
            o_nb_cid_x <= i_home_cid_x;  // offset 0 is the home cell itself
            o_nb_cid_y <= i_home_cid_y;
            o_nb_cid_z <= i_home_cid_z;
            o_nb_last  <= 1'b0;
            o_nb_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ISSUE;
          end else if (i_start) begin
            o_err <= 1'b1;
          end
        end
        ISSUE: begin
          if (i_nb_ready) begin
            if (k == 4'd13) begin
              k          <= '0;
              o_nb_valid <= 1'b0;
              o_nb_last  <= 1'b0;
              o_done     <= 1'b1;
              state      <= DONE;
            end else begin
              k          <= k_next;
              o_nb_cid_x <= nb_next[0];
              o_nb_cid_y <= nb_next[1];
              o_nb_cid_z <= nb_next[2];
              o_nb_last  <= (k_next == 4'd13);
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nb_cell_iter_ctrl.sv
// Scoreboard bench for nb_cell_iter_ctrl: stimulus pushes expected beats/done/err
// events into queues, a negedge monitor pops and compares them.

module tb_nb_cell_iter_ctrl;
  logic       clk = 0, rst_n = 0, i_start = 0, i_nb_ready = 1;
  logic [2:0] i_home_cid_x = 0, i_home_cid_y = 0, i_home_cid_z = 0;
  logic       o_busy, o_nb_valid, o_nb_last, o_done, o_err;
  logic [2:0] o_nb_cid_x, o_nb_cid_y, o_nb_cid_z;
  logic [3:0] o_nb_idx;

  nb_cell_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_home_cid_x(i_home_cid_x), .i_home_cid_y(i_home_cid_y), .i_home_cid_z(i_home_cid_z),
    .o_busy(o_busy), .o_nb_valid(o_nb_valid), .i_nb_ready(i_nb_ready),
    .o_nb_cid_x(o_nb_cid_x), .o_nb_cid_y(o_nb_cid_y), .o_nb_cid_z(o_nb_cid_z),
    .o_nb_idx(o_nb_idx), .o_nb_last(o_nb_last), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int beat_q[$], done_q[$], err_q[$];
  int last_done_cyc = -1, busy_from = 0;
  int rdy_mode = 0;          // 0: always ready, 1: random, 2: scheduled stalls
  int stall_left[14];
  bit prev_stall = 0;
  int prev_beat = 0;

  // Half-shell offsets and the literal home (1,1,1) sequence.
  int odx[14] = '{0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1};
  int ody[14] = '{0, 0, 1, 1, 1, -1, -1, -1, 0, 0, 0, 1, 1, 1};
  int odz[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int tx[14]  = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
  int ty[14]  = '{1, 1, 2, 2, 2, 0, 0, 0, 1, 1, 1, 2, 2, 2};
  int tz[14]  = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pack_beat(int x, int y, int z, int k, int last);
    return (x << 11) | (y << 8) | (z << 5) | (k << 1) | last;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready driver
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 1) i_nb_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 2 && o_nb_valid && stall_left[o_nb_idx] > 0) begin
      i_nb_ready = 0;
      stall_left[o_nb_idx]--;
    end else i_nb_ready = 1;
  end

  // Monitor
  always @(negedge clk) begin
    int cur, e;
    bit exp_busy;
    if (!rst_n) prev_stall = 0;
    else begin
      check(!(o_done && o_nb_valid), "done_valid_excl", int'(o_done), 0);
      exp_busy = (done_q.size() > 0) && (cyc >= busy_from);
      check(o_busy == exp_busy, "busy", int'(o_busy), int'(exp_busy));
      cur = pack_beat(o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_nb_idx, o_nb_last);
      if (prev_stall) check(o_nb_valid && cur == prev_beat, "stall_hold", cur, prev_beat);
      if (o_nb_valid && i_nb_ready) begin
        if (beat_q.size() == 0) check(0, "beat_unexpected", cur, -1);
        else begin
          e = beat_q.pop_front();
          check(cur == e, "beat", cur, e);
        end
      end
      prev_stall = o_nb_valid && !i_nb_ready;
      prev_beat  = cur;
      if (o_done) begin
        if (done_q.size() == 0) check(0, "done_unexpected", 1, 0);
        else begin
          e = done_q.pop_front();
          check(beat_q.size() == 0, "done_beats_left", beat_q.size(), 0);
          if (e >= 0) check(cyc == e, "done_cycle", cyc, e);
        end
        last_done_cyc = cyc;
      end else if (done_q.size() > 0 && done_q[0] >= 0 && cyc > done_q[0]) begin
        check(0, "done_missing", cyc, done_q[0]);
        done_q[0] = -1;
      end
      if (o_err) begin
        if (err_q.size() == 0) check(0, "err_unexpected", 1, 0);
        else begin
          e = err_q.pop_front();
          check(cyc == e, "err_cycle", cyc, e);
        end
      end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
        check(0, "err_missing", cyc, err_q[0]);
        void'(err_q.pop_front());
      end
    end
  end

  // Issue a one-cycle start; the model decides acceptance and pushes expectations.
  task automatic do_start(input int x, input int y, input int z, input int done_rel, input bit use_tbl);
    int c = cyc;
    bit idle = (done_q.size() == 0) && (c > last_done_cyc);
    bit ok = (x < 3) && (y < 3) && (z < 3);
    i_start = 1;
    i_home_cid_x = 3'(x); i_home_cid_y = 3'(y); i_home_cid_z = 3'(z);
    if (idle && ok) begin
      for (int k = 0; k < 14; k++) begin
        if (use_tbl) beat_q.push_back(pack_beat(tx[k], ty[k], tz[k], k, int'(k == 13)));
        else beat_q.push_back(pack_beat((x + odx[k] + 3) % 3, (y + ody[k] + 3) % 3,
                                        (z + odz[k] + 3) % 3, k, int'(k == 13)));
      end
      done_q.push_back(done_rel < 0 ? -1 : c + done_rel);
      busy_from = c + 1;
    end else if (idle) err_q.push_back(c + 1);
    @(posedge clk); #1;
    i_start = 0;
    i_home_cid_x = 3'($urandom_range(0, 7));
    i_home_cid_y = 3'($urandom_range(0, 7));
    i_home_cid_z = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((done_q.size() > 0 || err_q.size() > 0 || cyc <= last_done_cyc) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check(n < budget, "idle_timeout", n, budget);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int rx, ry, rz, n;
    repeat (3) @(posedge clk);
    #1;
    check({o_busy, o_nb_valid, o_nb_last, o_done, o_err} == 5'b0, "reset_flags",
          int'({o_busy, o_nb_valid, o_nb_last, o_done, o_err}), 0);
    check({o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_nb_idx} == 13'b0, "reset_data",
          int'({o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_nb_idx}), 0);
    rst_n = 1;
    idle_cycles(2);

    // 1: home (1,1,1), literal expected table
    do_start(1, 1, 1, 15, 1);
    wait_idle(40);
    // 2: wrap cases
    do_start(0, 0, 0, 15, 0);
    wait_idle(40);
    do_start(2, 2, 2, 15, 0);
    wait_idle(40);
    // 3: back-pressure on k3 (4 cycles) and k13 (2 cycles)
    for (int i = 0; i < 14; i++) stall_left[i] = 0;
    stall_left[3] = 4; stall_left[13] = 2;
    rdy_mode = 2;
    idle_cycles(1);
    do_start(1, 1, 1, 21, 1);
    wait_idle(60);
    rdy_mode = 0;
    idle_cycles(1);
    // 4: out-of-range start, then a normal one
    do_start(3, 0, 0, 15, 0);
    idle_cycles(3);
    do_start(1, 1, 1, 15, 1);
    wait_idle(40);
    // 5: starts during ISSUE and DONE are ignored; T+16 accepted
    do_start(1, 1, 1, 15, 1);          // T
    idle_cycles(3);                    // now T+4
    do_start(0, 2, 1, 15, 0);          // T+4, during ISSUE
    idle_cycles(10);                   // now T+15
    do_start(2, 0, 0, 15, 0);          // T+15, during DONE
    do_start(0, 0, 0, 15, 0);          // T+16, accepted
    wait_idle(40);
    // 6: reset at k=7
    do_start(1, 1, 1, 15, 0);
    n = 0;
    while (!(o_nb_valid && o_nb_idx == 4'd7) && n < 40) begin @(posedge clk); #1; n++; end
    check(n < 40, "reach_k7_timeout", n, 40);
    rst_n = 0;
    beat_q.delete(); done_q.delete(); err_q.delete();
    #1;
    check({o_busy, o_nb_valid, o_nb_last, o_done, o_err} == 5'b0, "async_reset_flags",
          int'({o_busy, o_nb_valid, o_nb_last, o_done, o_err}), 0);
    check({o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_nb_idx} == 13'b0, "async_reset_data",
          int'({o_nb_cid_x, o_nb_cid_y, o_nb_cid_z, o_nb_idx}), 0);
    idle_cycles(2);
    rst_n = 1;
    idle_cycles(20);
    do_start(2, 1, 0, 15, 0);
    wait_idle(40);

    // Random phase: random homes (some out of range), random ready, random start timing
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      rx = ($urandom_range(0, 7) == 0) ? 3 + $urandom_range(0, 4) : $urandom_range(0, 2);
      ry = ($urandom_range(0, 7) == 0) ? 3 + $urandom_range(0, 4) : $urandom_range(0, 2);
      rz = ($urandom_range(0, 7) == 0) ? 3 + $urandom_range(0, 4) : $urandom_range(0, 2);
      idle_cycles($urandom_range(0, 12));
      do_start(rx, ry, rz, -1, 0);
    end
    wait_idle(200);
    rdy_mode = 0;
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
